sad_requester: RTL and testbench
================================

# sad_requester

Initiator for the SAD core's control handshake: on a `start` request it pulses `init`, streams each pixel block from a synchronous memory into the datapath, signals `loaded` per block, waits for `out_done`, captures the SAD result and returns `ack`. It sits between the system bus/host logic and the SAD core, driving the inputs that the core's control FSM consumes (`init`, `loaded`, `ack`) and consuming its outputs (`en_sad`, `out_done`).

## Interface
- `DATA_W`, 8: pixel width.
- `BLK_LEN`, 16: samples per block.
- `SAD_W`, 16: SAD result width.
- `ADDR_W`, 10: memory address width.
- `MAX_BLOCKS`, 16: most blocks allowed per request.
- `TIMEOUT`, 1023: wait limit in cycles for `en_sad` or `out_done`.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one SAD computation; sampled only in IDLE.
- `base_addr`  in  ADDR_W  first sample address, latched on accepted `start`.
- `busy`  out  1  high in every state except IDLE.
- `init`  out  1  one-cycle pulse to the core.
- `loaded`  out  1  one-cycle pulse after each full block.
- `ack`  out  1  one-cycle pulse acknowledging `out_done`.
- `en_sad`  in  1  core ready to accept a block, or result present.
- `out_done`  in  1  core result valid.
- `sad_in`  in  SAD_W  core SAD value.
- `mem_rd`  out  1  memory read strobe.
- `mem_addr`  out  ADDR_W  read address.
- `mem_data`  in  DATA_W  read data, valid exactly 1 cycle after `mem_rd`.
- `blk_valid`  out  1  `blk_data` valid this cycle.
- `blk_data`  out  DATA_W  sample streamed to the datapath.
- `result`  out  SAD_W  captured SAD; holds its value until the next capture.
- `result_valid`  out  1  one-cycle pulse.
- `err`  out  1  one-cycle pulse on timeout or block overflow.

## Operation
- States: IDLE, INIT, WAIT_EN, FETCH, LOADED, ACK, DONE.
- **IDLE**
  - On `start`=1, latch `base_addr` into the address counter, clear `blk_cnt`, go to INIT.
  - `start` in any other state is ignored.
- **INIT:** `init`=1 for one cycle, then WAIT_EN.
- **WAIT_EN** (wait counter runs):
  - `en_sad`=1 and `out_done`=1: go to ACK.
  - `en_sad`=1, `out_done`=0 and `blk_cnt`<MAX_BLOCKS: go to FETCH.
  - `en_sad`=1, `out_done`=0 and `blk_cnt`=MAX_BLOCKS: pulse `err`, go to IDLE.
  - Counter reaches TIMEOUT: pulse `err`, go to IDLE.
  - The wait counter clears on every entry to WAIT_EN.
- **FETCH**
  - Issue `mem_rd` on BLK_LEN consecutive cycles; `mem_addr` increments by 1 after each read.
  - `blk_valid` and `blk_data` (=`mem_data`) follow each read by 1 cycle.
  - Leave one cycle after the last `blk_valid`.
- **LOADED:** `loaded`=1 for one cycle, increment `blk_cnt`, return to WAIT_EN.
- **ACK:** `result`<=`sad_in`; `ack`=1 for one cycle, then DONE.
- **DONE:** `result_valid`=1 for one cycle, then IDLE.
- `mem_addr` wraps modulo 2^ADDR_W with no error.
- `blk_cnt` width is clog2(MAX_BLOCKS+1).
- The address counter carries across blocks; it is not reloaded per block.

## Timing
- Reset (`rst_n`=0, asynchronous, any state): go to IDLE.
  - All outputs read 0, including `result` and `mem_addr`.
  - Counters clear.
  - Any in-flight read data is discarded; no `blk_valid` follows reset release.
- `start` at edge N: `busy` is 1 and `init` is 1 from N+1; WAIT_EN begins at N+2.
- Cycles per block, from the first `mem_rd` to `loaded`: `mem_rd` occupies BLK_LEN cycles, `blk_valid` covers cycles 1..BLK_LEN, `loaded` is at cycle BLK_LEN+1.
- `mem_rd` and `blk_valid` never assert outside FETCH.
- `init`, `loaded`, `ack`, `result_valid` and `err` are mutually exclusive and each lasts exactly one cycle.
- In DONE, `result` is already stable on the cycle `result_valid` is high.
- Any output pulse counts as a pulse only if sampled on the following edge.
- If `en_sad` and `out_done` are both high in WAIT_EN, ACK wins over FETCH.

## Test plan
- **Single block:** BLK_LEN=16, `base_addr`=0x010, memory[i]=i. Start, then the core model raises `en_sad`, later `en_sad`+`out_done` with `sad_in`=0x0123.
  - Required: one `init`; 16 `blk_valid` carrying 0x10..0x1F; one `loaded`; one `ack`; `result`=0x0123 with `result_valid` pulsing in the cycle after `ack`; `busy` back to 0.
- **Three blocks:** the core requests 3 blocks.
  - Required: three `loaded` pulses; `mem_addr` runs contiguously `base_addr`..`base_addr`+47; `blk_cnt` ends at 3.
- **Wrap:** `base_addr`=0x3F8 with ADDR_W=10.
  - Required: addresses 0x3F8..0x3FF then 0x000..0x007; `err` stays 0.
- **Timeout:** `en_sad` held at 0 after `init`.
  - Required: `err` pulses exactly TIMEOUT cycles after WAIT_EN is entered; state returns to IDLE; `ack` never asserts.
- **Overflow:** MAX_BLOCKS=2 and the core requests a third block.
  - Required: `err` pulse, return to IDLE, no third FETCH.
- **Reset and start-while-busy:** drop `rst_n` in the middle of FETCH, and separately pulse `start` during WAIT_EN.
  - Required after reset: all outputs 0 immediately, no further `blk_valid`.
  - Required for start-while-busy: the extra `start` is ignored, with no second `init`.

Source files
------------

// File: rtl/sad_requester.sv
// ============================================================================
// Module   : sad_requester
// Brief    : Handshake initiator for the SAD core. Pulses init, streams pixel
//            blocks from synchronous memory, waits for the result and acks it.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sad_requester #(
    parameter int DATA_W     = 8,
    parameter int BLK_LEN    = 16,
    parameter int SAD_W      = 16,
    parameter int ADDR_W     = 10,
    parameter int MAX_BLOCKS = 16,
    parameter int TIMEOUT    = 1023
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              busy,
    output logic              init,
    output logic              loaded,
    output logic              ack,
    input  logic              en_sad,
    input  logic              out_done,
    input  logic [SAD_W-1:0]  sad_in,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_data,
    output logic              blk_valid,
    output logic [DATA_W-1:0] blk_data,
    output logic [SAD_W-1:0]  result,
    output logic              result_valid,
    output logic              err
);

    localparam int c_BLK_W  = $clog2(MAX_BLOCKS + 1);
    localparam int c_FCNT_W = $clog2(BLK_LEN + 1);
    localparam int c_WCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    localparam logic [c_BLK_W-1:0]  c_BLK_MAX   = c_BLK_W'(MAX_BLOCKS);
    localparam logic [c_FCNT_W-1:0] c_FCNT_LAST = c_FCNT_W'(BLK_LEN);
    localparam logic [c_FCNT_W-1:0] c_FCNT_RD   = c_FCNT_W'(BLK_LEN);
    localparam logic [c_WCNT_W-1:0] c_WAIT_LAST = c_WCNT_W'(TIMEOUT - 1);

    localparam logic [2:0] c_IDLE    = 3'd0;
    localparam logic [2:0] c_INIT    = 3'd1;
    localparam logic [2:0] c_WAIT_EN = 3'd2;
    localparam logic [2:0] c_FETCH   = 3'd3;
    localparam logic [2:0] c_LOADED  = 3'd4;
    localparam logic [2:0] c_ACK     = 3'd5;
    localparam logic [2:0] c_DONE    = 3'd6;

    logic [2:0]          r_state;
    logic [2:0]          w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [c_BLK_W-1:0]  r_blk_cnt;
    logic [c_FCNT_W-1:0] r_fcnt;
    logic [c_WCNT_W-1:0] r_wcnt;
    logic                r_blk_valid;
    logic [SAD_W-1:0]    r_result;
    logic                r_err;
    logic                w_mem_rd;
    logic                w_err_set;
    logic                w_accept;

    assign w_accept = (r_state == c_IDLE) && start;
    // Reads occupy the first BLK_LEN FETCH cycles; the final cycle drains the last sample.
    assign w_mem_rd = (r_state == c_FETCH) && (r_fcnt < c_FCNT_RD);

    always_comb begin
        w_next    = r_state;
        w_err_set = 1'b0;
        case (r_state)
            c_IDLE:    if (start) w_next = c_INIT;
            c_INIT:    w_next = c_WAIT_EN;
            c_WAIT_EN: begin
                if (en_sad && out_done) begin
                    w_next = c_ACK;
                end else if (en_sad) begin
                    if (r_blk_cnt < c_BLK_MAX) begin
                        w_next = c_FETCH;
                    end else begin
                        w_next    = c_IDLE;
                        w_err_set = 1'b1;
                    end
                end else if (r_wcnt == c_WAIT_LAST) begin
                    w_next    = c_IDLE;
                    w_err_set = 1'b1;
                end
            end
            c_FETCH:   if (r_fcnt == c_FCNT_LAST) w_next = c_LOADED;
            c_LOADED:  w_next = c_WAIT_EN;
            c_ACK:     w_next = c_DONE;
            c_DONE:    w_next = c_IDLE;
            default:   w_next = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_IDLE;
            r_addr      <= '0;
            r_blk_cnt   <= '0;
            r_fcnt      <= '0;
            r_wcnt      <= '0;
            r_blk_valid <= 1'b0;
            r_result    <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_err       <= w_err_set;
            r_blk_valid <= w_mem_rd;

            // Address runs on across blocks and wraps silently.
            if (w_accept) begin
                r_addr <= base_addr;
            end else if (w_mem_rd) begin
                r_addr <= r_addr + ADDR_W'(1);
            end

            if (w_accept) begin
                r_blk_cnt <= '0;
            end else if (r_state == c_LOADED) begin
                r_blk_cnt <= r_blk_cnt + c_BLK_W'(1);
            end

            r_fcnt <= (r_state == c_FETCH) ? r_fcnt + c_FCNT_W'(1) : '0;
            r_wcnt <= (r_state == c_WAIT_EN) ? r_wcnt + c_WCNT_W'(1) : '0;

            if (r_state == c_ACK) begin
                r_result <= sad_in;
            end
        end
    end

    assign busy         = (r_state != c_IDLE);
    assign init         = (r_state == c_INIT);
    assign loaded       = (r_state == c_LOADED);
    assign ack          = (r_state == c_ACK);
    assign result_valid = (r_state == c_DONE);
    assign err          = r_err;
    assign mem_rd       = w_mem_rd;
    assign mem_addr     = r_addr;
    assign blk_valid    = r_blk_valid;
    assign blk_data     = r_blk_valid ? mem_data : '0;
    assign result       = r_result;

endmodule

`default_nettype wire

// File: tb/tb_sad_requester.sv
// ============================================================================
// Module   : tb_sad_requester
// Brief    : Directed, table-driven bench for sad_requester.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sad_requester;

    localparam int DATA_W  = 8;
    localparam int SAD_W   = 16;
    localparam int ADDR_W  = 10;
    localparam int TIMEOUT = 1023;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n, rst2_n, start, en_sad, out_done, sel2;
    logic [ADDR_W-1:0] base_addr;
    logic [SAD_W-1:0]  sad_in;

    logic              busy1, init1, loaded1, ack1, mem_rd1, blk_valid1, rv1, err1;
    logic [ADDR_W-1:0] mem_addr1;
    logic [DATA_W-1:0] mem_data1, blk_data1;
    logic [SAD_W-1:0]  result1;

    logic              busy2, init2, loaded2, ack2, mem_rd2, blk_valid2, rv2, err2;
    logic [ADDR_W-1:0] mem_addr2;
    logic [DATA_W-1:0] mem_data2, blk_data2;
    logic [SAD_W-1:0]  result2;

    sad_requester dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr),
        .busy(busy1), .init(init1), .loaded(loaded1), .ack(ack1),
        .en_sad(en_sad), .out_done(out_done), .sad_in(sad_in),
        .mem_rd(mem_rd1), .mem_addr(mem_addr1), .mem_data(mem_data1),
        .blk_valid(blk_valid1), .blk_data(blk_data1), .result(result1),
        .result_valid(rv1), .err(err1)
    );

    sad_requester #(.MAX_BLOCKS(2)) dut2 (
        .clk(clk), .rst_n(rst2_n), .start(start), .base_addr(base_addr),
        .busy(busy2), .init(init2), .loaded(loaded2), .ack(ack2),
        .en_sad(en_sad), .out_done(out_done), .sad_in(sad_in),
        .mem_rd(mem_rd2), .mem_addr(mem_addr2), .mem_data(mem_data2),
        .blk_valid(blk_valid2), .blk_data(blk_data2), .result(result2),
        .result_valid(rv2), .err(err2)
    );

    // Memory image: each location holds the low byte of its own address.
    always @(posedge clk) begin
        if (mem_rd1) mem_data1 <= mem_addr1[DATA_W-1:0];
        if (mem_rd2) mem_data2 <= mem_addr2[DATA_W-1:0];
    end

    wire              m_busy      = sel2 ? busy2      : busy1;
    wire              m_init      = sel2 ? init2      : init1;
    wire              m_loaded    = sel2 ? loaded2    : loaded1;
    wire              m_ack       = sel2 ? ack2       : ack1;
    wire              m_rv        = sel2 ? rv2        : rv1;
    wire              m_err       = sel2 ? err2       : err1;
    wire              m_mem_rd    = sel2 ? mem_rd2    : mem_rd1;
    wire              m_blk_valid = sel2 ? blk_valid2 : blk_valid1;
    wire [ADDR_W-1:0] m_mem_addr  = sel2 ? mem_addr2  : mem_addr1;
    wire [DATA_W-1:0] m_blk_data  = sel2 ? blk_data2  : blk_data1;

    int vec = 0, fails = 0;
    int cyc = 0, viol = 0;
    int n_init, n_loaded, n_ack, n_rv, n_err, n_rd, n_valid, addr_bad;
    int init_cyc, ack_cyc, rv_cyc, err_cyc;
    logic [DATA_W-1:0] first_data, last_data;
    logic [ADDR_W-1:0] exp_addr;
    logic [4:0]        prev_p = '0;

    always @(negedge clk) begin
        logic [4:0] p;
        cyc++;
        p = {m_init, m_loaded, m_ack, m_rv, m_err};
        if (($countones(p) > 1) || ((p & prev_p) != 5'd0)) viol++;
        if ((m_blk_valid || m_mem_rd) && !m_busy) viol++;
        prev_p = p;
        if (m_init)   begin n_init++;   init_cyc = cyc; end
        if (m_loaded) n_loaded++;
        if (m_ack)    begin n_ack++;    ack_cyc = cyc; end
        if (m_rv)     begin n_rv++;     rv_cyc = cyc; end
        if (m_err)    begin n_err++;    err_cyc = cyc; end
        if (m_mem_rd) begin
            n_rd++;
            if (m_mem_addr !== exp_addr) addr_bad++;
            exp_addr = m_mem_addr + ADDR_W'(1);
        end
        if (m_blk_valid) begin
            if (n_valid == 0) first_data = m_blk_data;
            last_data = m_blk_data;
            n_valid++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic clear_mon(input logic [ADDR_W-1:0] base);
        n_init = 0; n_loaded = 0; n_ack = 0; n_rv = 0; n_err = 0;
        n_rd = 0; n_valid = 0; addr_bad = 0;
        init_cyc = 0; ack_cyc = 0; rv_cyc = 0; err_cyc = 0;
        first_data = '0; last_data = '0; exp_addr = base;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the INIT cycle.
    task automatic do_start(input logic [ADDR_W-1:0] addr);
        base_addr = addr;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic grant(input logic done);
        en_sad   = 1'b1;
        out_done = done;
        tick();
        en_sad   = 1'b0;
        out_done = 1'b0;
    endtask

    task automatic wait_loaded();
        int k;
        k = 0;
        while (!m_loaded && k < 64) begin
            tick();
            k++;
        end
        vec++;
        if (!m_loaded) begin
            fails++;
            $display("FAIL wait_loaded: loaded not seen within %0d cycles", k);
        end
    endtask

    task automatic run_txn(input logic [ADDR_W-1:0] base, input int nblk, input logic [SAD_W-1:0] sad);
        clear_mon(base);
        sad_in = sad;
        do_start(base);
        tick();
        for (int b = 0; b < nblk; b++) begin
            grant(1'b0);
            wait_loaded();
            tick();
        end
        grant(1'b1);
        repeat (4) tick();
    endtask

    typedef struct {
        logic [ADDR_W-1:0] base;
        int                nblk;
        logic [SAD_W-1:0]  sad;
        int                exp_loaded;
        int                exp_valid;
        logic [DATA_W-1:0] exp_first;
        logic [DATA_W-1:0] exp_last;
        logic [ADDR_W-1:0] exp_end_addr;
    } txn_t;

    txn_t tbl [4];

    initial begin
        tbl[0] = '{10'h010, 1, 16'h0123, 1, 16, 8'h10, 8'h1F, 10'h020};
        tbl[1] = '{10'h100, 3, 16'hBEEF, 3, 48, 8'h00, 8'h2F, 10'h130};
        tbl[2] = '{10'h3F8, 1, 16'h0055, 1, 16, 8'hF8, 8'h07, 10'h008};
        tbl[3] = '{10'h3F0, 0, 16'hFFFF, 0, 0,  8'h00, 8'h00, 10'h3F0};

        rst_n = 1'b0; rst2_n = 1'b0; sel2 = 1'b0;
        start = 1'b0; en_sad = 1'b0; out_done = 1'b0;
        base_addr = '0; sad_in = '0;
        clear_mon('0);
        repeat (3) tick();
        check("reset_ctrl", {busy1, init1, loaded1, ack1, rv1, err1, mem_rd1, blk_valid1}, 0);
        check("reset_mem_addr", 32'(mem_addr1), 0);
        check("reset_result", 32'(result1), 0);
        check("reset_blk_data", 32'(blk_data1), 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 4; i++) begin
            run_txn(tbl[i].base, tbl[i].nblk, tbl[i].sad);
            check($sformatf("t%0d_init", i), n_init, 1);
            check($sformatf("t%0d_loaded", i), n_loaded, tbl[i].exp_loaded);
            check($sformatf("t%0d_valid", i), n_valid, tbl[i].exp_valid);
            check($sformatf("t%0d_first", i), 32'(first_data), 32'(tbl[i].exp_first));
            check($sformatf("t%0d_last", i), 32'(last_data), 32'(tbl[i].exp_last));
            check($sformatf("t%0d_addr_seq", i), addr_bad, 0);
            check($sformatf("t%0d_end_addr", i), 32'(mem_addr1), 32'(tbl[i].exp_end_addr));
            check($sformatf("t%0d_ack", i), n_ack, 1);
            check($sformatf("t%0d_rv_after_ack", i), rv_cyc - ack_cyc, 1);
            check($sformatf("t%0d_result", i), 32'(result1), 32'(tbl[i].sad));
            check($sformatf("t%0d_err", i), n_err, 0);
            check($sformatf("t%0d_busy", i), 32'(busy1), 0);
            check($sformatf("t%0d_blk_cnt", i), 32'(dut1.r_blk_cnt), tbl[i].nblk);
        end

        // Timeout: en_sad never rises after init.
        clear_mon('0);
        do_start(10'h200);
        begin
            int k;
            k = 0;
            while (!m_err && k < 1100) begin
                tick();
                k++;
            end
        end
        tick();
        check("timeout_err_count", n_err, 1);
        check("timeout_err_delay", err_cyc - init_cyc, TIMEOUT + 1);
        check("timeout_no_ack", n_ack, 0);
        check("timeout_idle", 32'(busy1), 0);

        // Extra start while waiting must not re-init or relatch the base.
        clear_mon(10'h020);
        sad_in = 16'h0AAA;
        do_start(10'h020);
        tick();
        base_addr = 10'h3FF;
        start = 1'b1;
        repeat (2) tick();
        start = 1'b0;
        check("swb_busy", 32'(busy1), 1);
        grant(1'b0);
        wait_loaded();
        tick();
        grant(1'b1);
        repeat (4) tick();
        check("swb_init_count", n_init, 1);
        check("swb_first", 32'(first_data), 32'h20);
        check("swb_result", 32'(result1), 32'h0AAA);

        // Asynchronous reset in the middle of a block.
        clear_mon(10'h050);
        do_start(10'h050);
        tick();
        grant(1'b0);
        repeat (5) tick();
        check("midfetch_valid", 32'(blk_valid1), 1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_ctrl", {busy1, init1, loaded1, ack1, rv1, err1, mem_rd1, blk_valid1}, 0);
        check("rst_mem_addr", 32'(mem_addr1), 0);
        check("rst_result", 32'(result1), 0);
        check("rst_blk_data", 32'(blk_data1), 0);
        tick();
        rst_n = 1'b1;
        clear_mon('0);
        repeat (20) tick();
        check("post_rst_valid", n_valid, 0);
        check("post_rst_rd", n_rd, 0);
        check("post_rst_busy", 32'(busy1), 0);

        // Overflow on the MAX_BLOCKS=2 instance.
        rst_n = 1'b0;
        rst2_n = 1'b1;
        sel2 = 1'b1;
        tick();
        clear_mon(10'h080);
        do_start(10'h080);
        tick();
        for (int b = 0; b < 2; b++) begin
            grant(1'b0);
            wait_loaded();
            tick();
        end
        grant(1'b0);
        repeat (4) tick();
        check("ovf_loaded", n_loaded, 2);
        check("ovf_err", n_err, 1);
        check("ovf_reads", n_rd, 32);
        check("ovf_valid", n_valid, 32);
        check("ovf_no_ack", n_ack, 0);
        check("ovf_idle", 32'(busy2), 0);

        check("pulse_rules", viol, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
        $finish;
    end

endmodule

`default_nettype wire
